// File: rtl/mbe_pkg.sv
// mbe_pkg: shared types and defaults for the MBE mantissa multiplier back end
package mbe_pkg;
    typedef enum logic [1:0] {IDLE, ADD, DONE} cpa_state_t;
    localparam int MANT_PROD_W = 48;
    localparam int CPA_SLICE   = 12;
endpackage

// File: rtl/mbe_final_cpa_if.sv
// mbe_final_cpa_if: row input and product output handshakes of the final CPA
interface mbe_final_cpa_if
    import mbe_pkg::*;
#(
    parameter int WIDTH = MANT_PROD_W
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] row0;
    logic [WIDTH-1:0] row1;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] product;
    logic             norm;
    logic             busy;
    modport master (
        output in_valid, row0, row1, out_ready,
        input  in_ready, out_valid, product, norm, busy
    );
    modport slave (
        input  in_valid, row0, row1, out_ready,
        output in_ready, out_valid, product, norm, busy
    );
endinterface

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);
    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

// File: rtl/mbe_final_cpa_slice.sv
// cpa_slice: SLICE-bit ripple adder built from full_adder cells
module cpa_slice
    import mbe_pkg::*;
#(
    parameter int SLICE = CPA_SLICE
) (
    input  logic [SLICE-1:0] i_a,
    input  logic [SLICE-1:0] i_b,
    input  logic             i_cin,
    output logic [SLICE-1:0] o_s,
    output logic             o_cout
);
    logic [SLICE:0] w_c;
    assign w_c[0] = i_cin;
    for (genvar i = 0; i < SLICE; i++) begin : g_fa
        full_adder u_fa (
            .i_a   (i_a[i]),
            .i_b   (i_b[i]),
            .i_cin (w_c[i]),
            .o_s   (o_s[i]),
            .o_cout(w_c[i+1])
        );
    end
    assign o_cout = w_c[SLICE];
endmodule

// File: rtl/mbe_final_cpa.sv
// mbe_final_cpa: resolves the sum/carry rows into one product, one slice per cycle
module mbe_final_cpa
    import mbe_pkg::*;
#(
    parameter int WIDTH = MANT_PROD_W,
    parameter int SLICE = CPA_SLICE
) (
    input  logic           clk,
    input  logic           rst_n,
    mbe_final_cpa_if.slave bus
);
    localparam int            NSLICE = WIDTH / SLICE;
    localparam int            CW     = NSLICE > 1 ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST   = CW'(NSLICE - 1);

    if (WIDTH % SLICE != 0) begin : g_bad_slice
        $error("mbe_final_cpa: WIDTH must be a multiple of SLICE");
    end

    cpa_state_t       r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_cy;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic [WIDTH-1:0] r_r0;
    logic [WIDTH-1:0] r_r1;
    logic [WIDTH-1:0] r_res;
    logic [SLICE-1:0] w_a;
    logic [SLICE-1:0] w_b;
    logic [SLICE-1:0] w_s;
    logic             w_c;

    assign w_a = r_r0[int'(r_cnt)*SLICE +: SLICE];
    assign w_b = r_r1[int'(r_cnt)*SLICE +: SLICE];

    cpa_slice #(.SLICE(SLICE)) u_slice (
        .i_a   (w_a),
        .i_b   (w_b),
        .i_cin (r_cy),
        .o_s   (w_s),
        .o_cout(w_c)
    );

    // FSM: latch rows, add one slice per cycle with registered carry, hold result until taken
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_cy        <= 1'b0;
            r_r0        <= '0;
            r_r1        <= '0;
            r_res       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_r0       <= bus.row0;
                    r_r1       <= bus.row1;
                    r_cnt      <= '0;
                    r_cy       <= 1'b0;
                    r_state    <= ADD;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b1;
                end
                ADD: begin
                    r_res[int'(r_cnt)*SLICE +: SLICE] <= w_s;
                    r_cy  <= w_c;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: if (bus.out_ready) begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.product   = r_res;
    assign bus.norm      = r_res[WIDTH-1];
endmodule

// File: tb/tb_mbe_final_cpa.sv
// tb_mbe_final_cpa: directed and random checks of the final CPA against a queue of expected sums
module tb_mbe_final_cpa;
    logic        clk;
    logic        rst_n;
    int          checks;
    int          failures;
    logic [47:0] sb[$];

    mbe_final_cpa_if #(.WIDTH(48)) bus ();

    mbe_final_cpa #(.WIDTH(48), .SLICE(12)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs are set just after a negedge; this scores the coming posedge and advances to the next negedge.
    task automatic tick();
        logic [47:0] e;
        if (!rst_n) sb.delete();
        else begin
            if (bus.out_valid && bus.out_ready) begin
                chk("sb_nonempty", 48'(sb.size() != 0), 48'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("sb_product", bus.product, e);
                    chk("sb_norm", 48'(bus.norm), 48'(e[47]));
                end
            end
            if (bus.in_valid && bus.in_ready) sb.push_back(bus.row0 + bus.row1);
        end
        @(negedge clk);
    endtask

    task automatic wait_out(input string tag, input int lat);
        int n;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 48'(n), 48'(lat));
    endtask

    task automatic run_op(input string tag, input logic [47:0] r0, input logic [47:0] r1,
                          input logic [47:0] ep, input logic en);
        bus.row0     = r0;
        bus.row1     = r1;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        wait_out({tag, "_lat"}, 4);
        chk(tag, bus.product, ep);
        chk({tag, "_norm"}, 48'(bus.norm), 48'(en));
        tick();
    endtask

    initial begin
        int pushed;
        int cyc;
        checks   = 0;
        failures = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.row0      = 48'h5;
        bus.row1      = 48'h6;
        bus.out_ready = 1'b1;
        @(negedge clk);
        repeat (3) begin
            tick();
            chk("rst_in_ready", 48'(bus.in_ready), 48'd1);
            chk("rst_out_valid", 48'(bus.out_valid), 48'd0);
            chk("rst_product", bus.product, 48'd0);
            chk("rst_busy", 48'(bus.busy), 48'd0);
        end
        rst_n = 1'b1;
        tick();
        chk("release_busy", 48'(bus.busy), 48'd1);
        chk("release_in_ready", 48'(bus.in_ready), 48'd0);
        bus.in_valid = 1'b0;
        wait_out("release_lat", 4);
        chk("release_product", bus.product, 48'hB);
        tick();

        run_op("cross", 48'h0000_00FF_FFFF, 48'h1, 48'h0000_0100_0000, 1'b0);
        run_op("wrap", 48'hFFFF_FFFF_FFFF, 48'h1, 48'h0, 1'b0);
        run_op("norm", 48'h8000_0000_0000, 48'h0, 48'h8000_0000_0000, 1'b1);

        bus.row0     = 48'h1234_5678_9ABC;
        bus.row1     = 48'h1111_1111_1111;
        bus.in_valid = 1'b1;
        tick();
        bus.row0      = 48'hAAAA_AAAA_AAAA;
        bus.row1      = 48'h0000_0000_1111;
        bus.out_ready = 1'b0;
        wait_out("bp_lat", 4);
        repeat (10) begin
            chk("bp_product", bus.product, 48'h2345_6789_ABCD);
            chk("bp_in_ready", 48'(bus.in_ready), 48'd0);
            chk("bp_out_valid", 48'(bus.out_valid), 48'd1);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        chk("bp_single_xfer", 48'(bus.out_valid), 48'd0);
        chk("bp_ready_again", 48'(bus.in_ready), 48'd1);
        tick();
        bus.in_valid = 1'b0;
        wait_out("bp_next_lat", 4);
        chk("bp_next_product", bus.product, 48'hAAAA_AAAA_BBBB);
        tick();

        bus.row0     = 48'h0000_0000_0ABC;
        bus.row1     = 48'h1;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_in_ready", 48'(bus.in_ready), 48'd1);
        chk("midrst_product", bus.product, 48'd0);
        chk("midrst_busy", 48'(bus.busy), 48'd0);
        repeat (8) begin
            chk("midrst_no_valid", 48'(bus.out_valid), 48'd0);
            tick();
        end

        pushed = 0;
        cyc    = 0;
        bus.in_valid = 1'b1;
        while (pushed < 10000 && cyc < 90000) begin
            bus.row0      = 48'({$urandom, $urandom});
            bus.row1      = 48'({$urandom, $urandom});
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (bus.in_ready) pushed++;
            tick();
            cyc++;
        end
        chk("rand_count", 48'(pushed), 48'd10000);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        cyc = 0;
        while (sb.size() != 0 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("rand_drain", 48'(sb.size()), 48'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
